// File: rtl/cond_ex_stage.sv
// ============================================================================
// cond_ex_stage : ID/EX register, NZCV flag register and condition gating.
// Optional perf counters enabled by defining COND_PERF_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module cond_ex_stage
`ifdef COND_PERF_EN
  #(parameter int CNT_W = 16)
`endif
(
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [3:0]       CondD,
  input  logic [1:0]       FlagWD,
  input  logic             PCSD,
  input  logic             RegWD,
  input  logic             MemWD,
  input  logic             MemtoRegD,
  input  logic             ALUSrcD,
  input  logic [1:0]       ALUControlD,
  input  logic [3:0]       ALUFlags,
  output logic             ALUSrcE,
  output logic             MemtoRegE,
  output logic [1:0]       ALUControlE,
  output logic             CondExE,
  output logic             PCSrcE,
  output logic             RegWriteE,
  output logic             MemWriteE,
`ifdef COND_PERF_EN
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SquashCnt,
`endif
  output logic [3:0]       Flags
);

  logic       valid_q, valid_d;
  logic [3:0] cond_q, cond_d;
  logic [1:0] flagw_q, flagw_d;
  logic       pcs_q, pcs_d;
  logic       regw_q, regw_d;
  logic       memw_q, memw_d;
  logic       memtoreg_q, memtoreg_d;
  logic       alusrc_q, alusrc_d;
  logic [1:0] aluctl_q, aluctl_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_pass;
  logic       n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond_q)
      4'h0: cond_pass = z_f;
      4'h1: cond_pass = ~z_f;
      4'h2: cond_pass = c_f;
      4'h3: cond_pass = ~c_f;
      4'h4: cond_pass = n_f;
      4'h5: cond_pass = ~n_f;
      4'h6: cond_pass = v_f;
      4'h7: cond_pass = ~v_f;
      4'h8: cond_pass = c_f & ~z_f;
      4'h9: cond_pass = ~c_f | z_f;
      4'hA: cond_pass = (n_f == v_f);
      4'hB: cond_pass = (n_f != v_f);
      4'hC: cond_pass = ~z_f & (n_f == v_f);
      4'hD: cond_pass = z_f | (n_f != v_f);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign CondExE     = valid_q & cond_pass;
  assign PCSrcE      = pcs_q & CondExE;
  assign RegWriteE   = regw_q & CondExE;
  assign MemWriteE   = memw_q & CondExE;
  assign ALUSrcE     = alusrc_q;
  assign MemtoRegE   = memtoreg_q;
  assign ALUControlE = aluctl_q;
  assign Flags       = flags_q;

  always_comb begin
    valid_d    = valid_q;
    cond_d     = cond_q;
    flagw_d    = flagw_q;
    pcs_d      = pcs_q;
    regw_d     = regw_q;
    memw_d     = memw_q;
    memtoreg_d = memtoreg_q;
    alusrc_d   = alusrc_q;
    aluctl_d   = aluctl_q;
    if (FlushE) begin
      valid_d    = 1'b0;
      cond_d     = 4'hE;
      flagw_d    = 2'b00;
      pcs_d      = 1'b0;
      regw_d     = 1'b0;
      memw_d     = 1'b0;
      memtoreg_d = 1'b0;
      alusrc_d   = 1'b0;
      aluctl_d   = 2'b00;
    end else if (!StallE) begin
      valid_d    = 1'b1;
      cond_d     = CondD;
      flagw_d    = FlagWD;
      pcs_d      = PCSD;
      regw_d     = RegWD;
      memw_d     = MemWD;
      memtoreg_d = MemtoRegD;
      alusrc_d   = ALUSrcD;
      aluctl_d   = ALUControlD;
    end
  end

  // The instruction leaving E commits its flags even when the slot is flushed.
  always_comb begin
    flags_d = flags_q;
    if (CondExE && !StallE) begin
      if (flagw_q[1]) flags_d[3:2] = ALUFlags[3:2];
      if (flagw_q[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      cond_q     <= 4'h0;
      flagw_q    <= 2'b00;
      pcs_q      <= 1'b0;
      regw_q     <= 1'b0;
      memw_q     <= 1'b0;
      memtoreg_q <= 1'b0;
      alusrc_q   <= 1'b0;
      aluctl_q   <= 2'b00;
      flags_q    <= 4'h0;
    end else begin
      valid_q    <= valid_d;
      cond_q     <= cond_d;
      flagw_q    <= flagw_d;
      pcs_q      <= pcs_d;
      regw_q     <= regw_d;
      memw_q     <= memw_d;
      memtoreg_q <= memtoreg_d;
      alusrc_q   <= alusrc_d;
      aluctl_q   <= aluctl_d;
      flags_q    <= flags_d;
    end
  end

`ifdef COND_PERF_EN
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  always_comb begin
    exec_cnt_d   = exec_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (valid_q && !StallE) begin
      if (CondExE) exec_cnt_d   = exec_cnt_q + 1'b1;
      else         squash_cnt_d = squash_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_cnt_q   <= '0;
      squash_cnt_q <= '0;
    end else begin
      exec_cnt_q   <= exec_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign ExecCnt   = exec_cnt_q;
  assign SquashCnt = squash_cnt_q;
`endif

endmodule

`default_nettype wire
